// File: rtl/oracle_pkg.sv
// Shared definitions for the oracle sequence controller: FSM states and
// default sizing for the vector buffer, core inputs and core reset window.
package oracle_pkg;

    localparam int DEF_SEQ_MAX = 8;
    localparam int DEF_IN_W    = 4;
    localparam int DEF_RST_CYC = 2;
    localparam int QCNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CRST,
        RUN,
        RESP
    } state_t;

endpackage

// File: rtl/oracle_seq_ctrl_if.sv
// Host-side query bus of the oracle sequence controller: query start,
// vector load handshake and response handshake.
interface oracle_seq_ctrl_if
    import oracle_pkg::*;
#(
    parameter int SEQ_MAX = DEF_SEQ_MAX,
    parameter int IN_W    = DEF_IN_W
);

    localparam int LEN_W = $clog2(SEQ_MAX + 1);

    logic               start_i;
    logic [LEN_W-1:0]   seq_len_i;
    logic               vec_valid_i;
    logic               vec_ready_o;
    logic [IN_W-1:0]    vec_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic [SEQ_MAX-1:0] resp_o;
    logic               err_o;
    logic               busy_o;

    modport master (
        output start_i, seq_len_i, vec_valid_i, vec_i, resp_ready_i,
        input  vec_ready_o, resp_valid_o, resp_o, err_o, busy_o
    );

    modport slave (
        input  start_i, seq_len_i, vec_valid_i, vec_i, resp_ready_i,
        output vec_ready_o, resp_valid_o, resp_o, err_o, busy_o
    );

endinterface

// File: rtl/oracle_vec_buf.sv
// Query vector store: one synchronous write port, one asynchronous read port.
// Deliberately unreset; every slot is written in LOAD before RUN reads it.
module oracle_vec_buf
    import oracle_pkg::*;
#(
    parameter int SEQ_MAX = DEF_SEQ_MAX,
    parameter int IN_W    = DEF_IN_W
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(SEQ_MAX)-1:0] wr_addr,
    input  logic [IN_W-1:0]            wr_data,
    input  logic [$clog2(SEQ_MAX)-1:0] rd_addr,
    output logic [IN_W-1:0]            rd_data
);

    logic [IN_W-1:0] mem [SEQ_MAX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/oracle_seq_ctrl.sv
// Sequences a test core through load, reset, run and response phases.
// Define ORACLE_QCNT_EN to add the 16-bit answered-query counter qcnt_o.
module oracle_seq_ctrl
    import oracle_pkg::*;
#(
    parameter int SEQ_MAX = DEF_SEQ_MAX,
    parameter int IN_W    = DEF_IN_W,
    parameter int RST_CYC = DEF_RST_CYC
) (
    input  logic              CLK,
    input  logic              RN,
    oracle_seq_ctrl_if.slave  host,
    output logic [IN_W-1:0]   core_in_o,
    output logic              core_rn_o,
    input  logic              core_out_i
`ifdef ORACLE_QCNT_EN
    ,
    output logic [QCNT_W-1:0] qcnt_o
`endif
);

    localparam int LEN_W = $clog2(SEQ_MAX + 1);
    localparam int IDX_W = $clog2(SEQ_MAX);
    localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t             state;
    logic [LEN_W-1:0]   seq_len;
    logic [LEN_W-1:0]   idx;
    logic [RC_W-1:0]    rst_cnt;
    logic [SEQ_MAX-1:0] resp;
    logic               vec_ready;
    logic               resp_valid;
    logic               err;
    logic               busy;

    logic [LEN_W-1:0]   idx_next;
    logic               last_idx;
    logic               len_ok;
    logic               wr_en;
    logic [IDX_W-1:0]   rd_addr;
    logic [IN_W-1:0]    rd_data;

    assign idx_next = idx + LEN_W'(1);
    assign last_idx = (idx == seq_len - LEN_W'(1));
    assign len_ok   = (host.seq_len_i != '0) && (host.seq_len_i <= LEN_W'(SEQ_MAX));
    assign wr_en    = (state == LOAD) && vec_ready && host.vec_valid_i;

    // RUN registers the next vector one cycle ahead, so read idx+1 there and slot 0 otherwise
    assign rd_addr  = ((state == RUN) && (idx_next < seq_len)) ? idx_next[IDX_W-1:0] : '0;

    oracle_vec_buf #(
        .SEQ_MAX (SEQ_MAX),
        .IN_W    (IN_W)
    ) u_vec_buf (
        .clk     (CLK),
        .we      (wr_en),
        .wr_addr (idx[IDX_W-1:0]),
        .wr_data (host.vec_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state      <= IDLE;
            seq_len    <= '0;
            idx        <= '0;
            rst_cnt    <= '0;
            resp       <= '0;
            vec_ready  <= 1'b0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            core_in_o  <= '0;
            core_rn_o  <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.start_i) begin
                        if (len_ok) begin
                            state     <= LOAD;
                            seq_len   <= host.seq_len_i;
                            idx       <= '0;
                            resp      <= '0;
                            vec_ready <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (host.vec_valid_i) begin
                        if (last_idx) begin
                            state     <= CRST;
                            idx       <= '0;
                            rst_cnt   <= '0;
                            vec_ready <= 1'b0;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end
                CRST: begin
                    if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                        state     <= RUN;
                        core_rn_o <= 1'b1;
                        core_in_o <= rd_data;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                RUN: begin
                    // Sample the core at the same edge that advances it past vector idx
                    resp[idx[IDX_W-1:0]] <= core_out_i;
                    if (last_idx) begin
                        state      <= RESP;
                        idx        <= '0;
                        core_rn_o  <= 1'b0;
                        core_in_o  <= '0;
                        resp_valid <= 1'b1;
                    end else begin
                        idx       <= idx_next;
                        core_in_o <= rd_data;
                    end
                end
                RESP: begin
                    if (host.resp_ready_i) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    vec_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    core_rn_o  <= 1'b0;
                    core_in_o  <= '0;
                end
            endcase
        end
    end

`ifdef ORACLE_QCNT_EN
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            qcnt_o <= '0;
        end else if (resp_valid && host.resp_ready_i) begin
            qcnt_o <= qcnt_o + QCNT_W'(1);
        end
    end
`endif

    assign host.vec_ready_o  = vec_ready;
    assign host.resp_valid_o = resp_valid;
    assign host.resp_o       = resp;
    assign host.err_o        = err;
    assign host.busy_o       = busy;

endmodule

// File: tb/tb_oracle_seq_ctrl.sv
// Directed bench for oracle_seq_ctrl with a wire core stub (out = in[0]).
// Build with ORACLE_QCNT_EN defined to also check the query counter.
module tb_oracle_seq_ctrl;
    import oracle_pkg::*;

    localparam int SEQ_MAX = 8;
    localparam int IN_W    = 4;
    localparam int RST_CYC = 2;
    localparam int LEN_W   = 4;
    localparam int BUDGET  = 200;

    logic            CLK = 1'b0;
    logic            RN  = 1'b0;
    logic [IN_W-1:0] core_in;
    logic            core_rn;
    logic            core_out;
`ifdef ORACLE_QCNT_EN
    logic [15:0]     qcnt;
`endif

    oracle_seq_ctrl_if #(.SEQ_MAX(SEQ_MAX), .IN_W(IN_W)) bus ();

    oracle_seq_ctrl #(
        .SEQ_MAX (SEQ_MAX),
        .IN_W    (IN_W),
        .RST_CYC (RST_CYC)
    ) dut (
        .CLK        (CLK),
        .RN         (RN),
        .host       (bus),
        .core_in_o  (core_in),
        .core_rn_o  (core_rn),
        .core_out_i (core_out)
`ifdef ORACLE_QCNT_EN
        ,
        .qcnt_o     (qcnt)
`endif
    );

    assign core_out = core_in[0];

    always #5 CLK = ~CLK;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              hs_count = 0;
    logic [3:0]      vec_tab [SEQ_MAX];
    logic [7:0]      q_resp;
    int              q_lat, q_crst, q_run, q_gap;
    bit              q_data_ok, q_side_ok, q_timeout;

    // Runs one query up to resp_valid; the start cycle carries a junk vector that must be ignored
    task automatic do_query(input int len, input bit rand_valid);
        int i;
        int cyc;
        bit hs;
        q_crst = 0; q_run = 0; q_gap = 0;
        q_data_ok = 1'b1; q_side_ok = 1'b1; q_timeout = 1'b0;
        bus.start_i     = 1'b1;
        bus.seq_len_i   = LEN_W'(len);
        bus.vec_valid_i = 1'b1;
        bus.vec_i       = ~vec_tab[0];
        @(posedge CLK); #1;
        bus.start_i   = 1'b0;
        bus.seq_len_i = '0;
        cyc = 1;
        i   = 0;
        while (i < len && cyc < BUDGET) begin
            bus.vec_valid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.vec_i       = bus.vec_valid_i ? vec_tab[i] : ~vec_tab[i];
            hs = bus.vec_valid_i && bus.vec_ready_o;
            @(posedge CLK); #1;
            cyc++;
            if (hs) i++;
        end
        bus.vec_valid_i = 1'b0;
        bus.vec_i       = '0;
        while (!bus.resp_valid_o && cyc < BUDGET) begin
            if (bus.vec_ready_o !== 1'b0 || bus.busy_o !== 1'b1) q_side_ok = 1'b0;
            if (core_rn === 1'b1) begin
                if (q_run < len && core_in !== vec_tab[q_run]) q_data_ok = 1'b0;
                q_run++;
            end else if (q_run == 0) begin
                q_crst++;
                if (core_in !== '0) q_side_ok = 1'b0;
            end else begin
                q_gap++;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        q_timeout = !bus.resp_valid_o;
        q_lat     = cyc;
        q_resp    = bus.resp_o;
    endtask

    task automatic accept();
        bus.resp_ready_i = 1'b1;
        @(posedge CLK); #1;
        bus.resp_ready_i = 1'b0;
        hs_count++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.vec_ready_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_vec_ready: got %b want 0", bus.vec_ready_o); end
        n_cmp++; if (bus.resp_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_resp_valid: got %b want 0", bus.resp_valid_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err: got %b want 0", bus.err_o); end
        n_cmp++; if (core_rn !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_core_rn: got %b want 0", core_rn); end
        n_cmp++; if (core_in !== 4'h0) begin n_bad++; $display("[TB] FAIL rst_core_in: got %h want 0", core_in); end
        n_cmp++; if (bus.resp_o !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_resp: got %h want 00", bus.resp_o); end
`ifdef ORACLE_QCNT_EN
        n_cmp++; if (qcnt !== 16'h0000) begin n_bad++; $display("[TB] FAIL rst_qcnt: got %h want 0000", qcnt); end
`endif
        RN = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_busy: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_basic();
        vec_tab = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(4, 1'b0);
        n_cmp++; if (q_timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_timeout: no resp_valid within %0d cycles", BUDGET); end
        n_cmp++; if (q_resp !== 8'h0D) begin n_bad++; $display("[TB] FAIL basic_resp: got %h want 0d", q_resp); end
        n_cmp++; if (q_lat !== 11) begin n_bad++; $display("[TB] FAIL basic_latency: got %0d want 11", q_lat); end
        n_cmp++; if (q_crst !== RST_CYC) begin n_bad++; $display("[TB] FAIL basic_crst_cycles: got %0d want %0d", q_crst, RST_CYC); end
        n_cmp++; if (q_run !== 4 || q_gap !== 0) begin n_bad++; $display("[TB] FAIL basic_run: got run=%0d gap=%0d want run=4 gap=0", q_run, q_gap); end
        n_cmp++; if (q_data_ok !== 1'b1 || q_side_ok !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_core_drive: got data_ok=%b side_ok=%b want 1 1", q_data_ok, q_side_ok); end
        accept();
        n_cmp++; if ({bus.resp_valid_o, bus.busy_o} !== 2'b00) begin n_bad++; $display("[TB] FAIL basic_release: got valid/busy=%b want 00", {bus.resp_valid_o, bus.busy_o}); end
    endtask

    task automatic test_bad_len();
        int bad_lens [3] = '{0, 9, 15};
        for (int j = 0; j < 3; j++) begin
            bus.start_i   = 1'b1;
            bus.seq_len_i = LEN_W'(bad_lens[j]);
            @(posedge CLK); #1;
            bus.start_i   = 1'b0;
            bus.seq_len_i = '0;
            n_cmp++; if ({bus.err_o, bus.busy_o, bus.vec_ready_o} !== 3'b100) begin n_bad++; $display("[TB] FAIL badlen_%0d_pulse: got err/busy/ready=%b want 100", bad_lens[j], {bus.err_o, bus.busy_o, bus.vec_ready_o}); end
            @(posedge CLK); #1;
            n_cmp++; if ({bus.err_o, bus.busy_o} !== 2'b00) begin n_bad++; $display("[TB] FAIL badlen_%0d_after: got err/busy=%b want 00", bad_lens[j], {bus.err_o, bus.busy_o}); end
        end
    endtask

    task automatic test_boundaries();
        vec_tab = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(1, 1'b0);
        n_cmp++; if (q_resp !== 8'h01 || q_lat !== 5) begin n_bad++; $display("[TB] FAIL len1: got resp=%h lat=%0d want 01 5", q_resp, q_lat); end
        accept();
        vec_tab = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        do_query(SEQ_MAX, 1'b0);
        n_cmp++; if (q_resp !== 8'hFF || q_lat !== 19) begin n_bad++; $display("[TB] FAIL full_ones: got resp=%h lat=%0d want ff 19", q_resp, q_lat); end
        n_cmp++; if (q_data_ok !== 1'b1 || q_run !== 8) begin n_bad++; $display("[TB] FAIL full_ones_run: got data_ok=%b run=%0d want 1 8", q_data_ok, q_run); end
        accept();
        vec_tab = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        do_query(SEQ_MAX, 1'b0);
        n_cmp++; if (q_resp !== 8'hAA || q_data_ok !== 1'b1) begin n_bad++; $display("[TB] FAIL full_alt: got resp=%h data_ok=%b want aa 1", q_resp, q_data_ok); end
        accept();
    endtask

    task automatic test_random_valid();
        vec_tab = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(4, 1'b1);
        n_cmp++; if (q_timeout !== 1'b0 || q_resp !== 8'h0D) begin n_bad++; $display("[TB] FAIL rand_resp: got resp=%h timeout=%b want 0d 0", q_resp, q_timeout); end
        n_cmp++; if (q_run !== 4 || q_gap !== 0 || q_crst !== RST_CYC) begin n_bad++; $display("[TB] FAIL rand_run: got run=%0d gap=%0d crst=%0d want 4 0 %0d", q_run, q_gap, q_crst, RST_CYC); end
        accept();
        vec_tab = '{4'h1, 4'hE, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(3, 1'b1);
        n_cmp++; if (q_resp !== 8'h05 || q_data_ok !== 1'b1) begin n_bad++; $display("[TB] FAIL rand_len3: got resp=%h data_ok=%b want 05 1", q_resp, q_data_ok); end
        accept();
    endtask

    task automatic test_backpressure();
        vec_tab = '{4'h6, 4'h9, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(3, 1'b0);
        n_cmp++; if (q_resp !== 8'h06) begin n_bad++; $display("[TB] FAIL bp_resp: got %h want 06", q_resp); end
        bus.start_i     = 1'b1;
        bus.seq_len_i   = LEN_W'(2);
        bus.vec_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            n_cmp++; if ({bus.resp_valid_o, bus.busy_o, bus.resp_o, bus.err_o, bus.vec_ready_o} !== {2'b11, 8'h06, 2'b00}) begin n_bad++; $display("[TB] FAIL bp_hold_%0d: got valid/busy/resp/err/ready=%b want 11_00000110_00", c, {bus.resp_valid_o, bus.busy_o, bus.resp_o, bus.err_o, bus.vec_ready_o}); end
        end
        bus.start_i     = 1'b0;
        bus.seq_len_i   = '0;
        bus.vec_valid_i = 1'b0;
        accept();
        n_cmp++; if ({bus.resp_valid_o, bus.busy_o} !== 2'b00) begin n_bad++; $display("[TB] FAIL bp_release: got valid/busy=%b want 00", {bus.resp_valid_o, bus.busy_o}); end
        @(posedge CLK); #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_stays_idle: got busy=%b want 0", bus.busy_o); end
    endtask

    task automatic test_abort();
        int w;
        vec_tab = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        bus.start_i   = 1'b1;
        bus.seq_len_i = LEN_W'(4);
        @(posedge CLK); #1;
        bus.start_i   = 1'b0;
        bus.seq_len_i = '0;
        for (int i = 0; i < 4; i++) begin
            bus.vec_valid_i = 1'b1;
            bus.vec_i       = vec_tab[i];
            @(posedge CLK); #1;
        end
        bus.vec_valid_i = 1'b0;
        w = 0;
        while (core_rn !== 1'b1 && w < BUDGET) begin
            @(posedge CLK); #1;
            w++;
        end
        n_cmp++; if (core_rn !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_reach_run: got core_rn=%b want 1", core_rn); end
        repeat (2) begin @(posedge CLK); #1; end
        RN = 1'b0;
        #1;
        hs_count = 0;
        n_cmp++; if ({bus.busy_o, bus.resp_valid_o, bus.vec_ready_o, bus.err_o, core_rn} !== 5'b00000) begin n_bad++; $display("[TB] FAIL abort_ctrl: got busy/valid/ready/err/rn=%b want 00000", {bus.busy_o, bus.resp_valid_o, bus.vec_ready_o, bus.err_o, core_rn}); end
        n_cmp++; if ({core_in, bus.resp_o} !== 12'h000) begin n_bad++; $display("[TB] FAIL abort_data: got core_in=%h resp=%h want 0 00", core_in, bus.resp_o); end
`ifdef ORACLE_QCNT_EN
        n_cmp++; if (qcnt !== 16'h0000) begin n_bad++; $display("[TB] FAIL abort_qcnt: got %h want 0000", qcnt); end
`endif
        @(posedge CLK); #3;
        RN = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if ({bus.resp_valid_o, bus.busy_o} !== 2'b00) begin n_bad++; $display("[TB] FAIL abort_no_partial: got valid/busy=%b want 00", {bus.resp_valid_o, bus.busy_o}); end
        vec_tab = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(3, 1'b0);
        n_cmp++; if (q_resp !== 8'h06 || q_lat !== 9) begin n_bad++; $display("[TB] FAIL abort_next: got resp=%h lat=%0d want 06 9", q_resp, q_lat); end
        accept();
    endtask

    task automatic test_back_to_back();
        vec_tab = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_query(2, 1'b0);
        n_cmp++; if (q_resp !== 8'h01 || q_lat !== 7) begin n_bad++; $display("[TB] FAIL b2b_q1: got resp=%h lat=%0d want 01 7", q_resp, q_lat); end
        accept();
        vec_tab = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        do_query(5, 1'b0);
        n_cmp++; if (q_resp !== 8'h1A || q_lat !== 13) begin n_bad++; $display("[TB] FAIL b2b_q2: got resp=%h lat=%0d want 1a 13", q_resp, q_lat); end
        accept();
        vec_tab = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        do_query(8, 1'b0);
        n_cmp++; if (q_resp !== 8'h7F || q_lat !== 19) begin n_bad++; $display("[TB] FAIL b2b_q3: got resp=%h lat=%0d want 7f 19", q_resp, q_lat); end
        accept();
`ifdef ORACLE_QCNT_EN
        n_cmp++; if (qcnt !== 16'(hs_count)) begin n_bad++; $display("[TB] FAIL b2b_qcnt: got %0d want %0d", qcnt, hs_count); end
`endif
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.seq_len_i    = '0;
        bus.vec_valid_i  = 1'b0;
        bus.vec_i        = '0;
        bus.resp_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_bad_len();
        test_boundaries();
        test_random_valid();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/oracle_seq_ctrl.md
ORACLE_SEQ_CTRL -- requirements
Module: oracle_seq_ctrl

Interface
REQ-001 Parameter SEQ_MAX, default 8, maximum vectors per query (2..32).
REQ-002 Parameter IN_W, default 4, core primary-input width.
REQ-003 Parameter RST_CYC, default 2, cycles core reset is held before a run (>=1).
REQ-004 CLK  in  1  single clock, rising edge; drives controller and attached core.
REQ-005 RN  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  begin query; sampled in IDLE only.
REQ-007 seq_len_i  in  $clog2(SEQ_MAX+1)  vectors in this query; captured on start.
REQ-008 vec_valid_i / vec_ready_o  in/out  1  vector load handshake.
REQ-009 vec_i  in  IN_W  input vector for the core.
REQ-010 core_in_o  out  IN_W  registered drive to core primary inputs.
REQ-011 core_rn_o  out  1  registered active-low reset to core flops.
REQ-012 core_out_i  in  1  core primary output (G17-style).
REQ-013 resp_valid_o / resp_ready_i  out/in  1  response handshake.
REQ-014 resp_o  out  SEQ_MAX  captured outputs, bit k = response to vector k.
REQ-015 err_o  out  1  one-cycle pulse on rejected start.
REQ-016 busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, LOAD, CRST, RUN, RESP; single state register.
REQ-018 IDLE: start_i with seq_len_i in 1..SEQ_MAX -> LOAD; with 0 or >SEQ_MAX -> stay IDLE, err_o pulses next cycle.
REQ-019 LOAD: vec_ready_o=1; each vec_valid_i&vec_ready_o writes vec_i to buffer slot idx, idx++; after seq_len-th write -> CRST next cycle.
REQ-020 CRST: core_rn_o=0 for exactly RST_CYC cycles, core_in_o=0, then -> RUN.
REQ-021 RUN: cycle k (k=0..seq_len-1) core_rn_o=1, core_in_o=buffer[k]; at end of cycle k resp bit k <= core_out_i; after k=seq_len-1 -> RESP.
REQ-022 Core therefore advances exactly seq_len clock edges with reset released; no gaps, no stalls in RUN.
REQ-023 RESP: resp_valid_o=1, resp_o stable; resp bits >= seq_len read 0; on resp_valid_o&resp_ready_i -> IDLE next cycle.
REQ-024 resp_o cleared to 0 on entry to LOAD.
REQ-025 Outside RUN, core_rn_o=0 and core_in_o=0 (core held in reset).
REQ-026 vec_ready_o=0 and start_i ignored in all states but LOAD/IDLE respectively.
REQ-027 start_i asserted with vec_valid_i in same cycle: vector not accepted until LOAD.
REQ-028 Latency start->resp_valid_o = 1 + seq_len (at full-rate load) + RST_CYC + seq_len cycles.

Reset
REQ-029 RN low: state=IDLE, idx=0, resp_o=0, core_in_o=0, core_rn_o=0, resp_valid_o=0, vec_ready_o=0, err_o=0, busy_o=0.
REQ-030 RN asserted mid-query aborts immediately; no partial response is ever presented.
REQ-031 Buffer contents not reset; never read before written in current query.

Configuration
REQ-032 Macro ORACLE_QCNT_EN defined: adds output qcnt_o (16 bits), reset 0, incremented on each response handshake, wraps 0xFFFF->0.
REQ-033 Macro undefined: qcnt_o port and counter absent; all other behaviour identical.

Structure
REQ-034 Package oracle_pkg holds FSM state enum, SEQ_MAX/IN_W/RST_CYC defaults, QCNT_W=16.
REQ-035 Sub-module oracle_vec_buf: SEQ_MAX x IN_W register file, one write port, one async read port, no reset.
REQ-036 Controller FSM, index counter, reset-cycle counter, response shift/capture in oracle_seq_ctrl.

Verification
REQ-037 Core stub core_out_i=core_in_o[0]; seq_len=4, vectors 1,0,1,1 -> resp_o=0b1101, RST_CYC cycles of core_rn_o=0 precede first vector.
REQ-038 start with seq_len=0 -> err_o one pulse, busy_o stays 0; seq_len=SEQ_MAX with 0xF vectors -> resp_o all ones.
REQ-039 vec_valid_i toggled 50% random during LOAD -> identical resp_o as full-rate load; RUN still contiguous.
REQ-040 resp_ready_i held 0 for 10 cycles -> resp_o/resp_valid_o stable; release -> IDLE next cycle.
REQ-041 RN pulsed low during RUN cycle 2 -> all outputs at reset values; next query of 3 vectors correct.
REQ-042 With ORACLE_QCNT_EN and real s27 netlist: 3 back-to-back queries match golden model, qcnt_o=3.
